// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator controller: FSM state encoding,
// result-address width and the address-counter increment helper.
package acc_pkg;

   localparam int ACC_ADDR_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ACCUM = 3'd2,
      DRAIN = 3'd3,
      STORE = 3'd4
   } acc_state_t;

   // Natural 4-bit wrap: 15 -> 0.
   function automatic logic [ACC_ADDR_W-1:0] next_addr(input logic [ACC_ADDR_W-1:0] addr);
      return addr + ACC_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/acc_beat_counter.sv
// Shared up-counter for ACCUM beats and DRAIN cycles; last flags that the next
// enabled cycle reaches limit, compared one bit wider so limit = all-ones never wraps.
module acc_beat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             last
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/accumulator_ctrl.sv
// Tile controller sequencing clear / accumulate / drain / store for one output tile.
// Optional feature: define ACC_CTRL_AUTO_ADDR_EN to use an internal wrapping address counter.
module accumulator_ctrl
   import acc_pkg::*;
#(
   parameter int ARR_SIZE     = 4,
   parameter int LEN_W        = 8,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic [ACC_ADDR_W-1:0] cmd_addr,
   input  logic                  beat_valid,
   output logic                  acc_reset,
   output logic                  store_output,
   output logic [ACC_ADDR_W-1:0] op_buffer_address,
   output logic                  busy,
   output logic                  done,
   output logic                  err_overrun
);

   // Counter must hold both the beat count and DRAIN_CYCLES (up to 15).
   localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
   localparam int unused_arr_size = ARR_SIZE;

   acc_state_t            state;
   logic [LEN_W-1:0]      len_q;
   logic [ACC_ADDR_W-1:0] addr_q;
   logic                  cnt_load;
   logic                  cnt_en;
   logic [CNT_W-1:0]      cnt_limit;
   logic                  cnt_last;

`ifdef ACC_CTRL_AUTO_ADDR_EN
   logic unused_cmd_addr;
   assign unused_cmd_addr = ^cmd_addr;
`endif

   always_comb begin
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      cnt_limit = CNT_W'(len_q);
      unique case (state)
         CLEAR: cnt_load = 1'b1;
         ACCUM: begin
            cnt_en   = beat_valid;
            cnt_load = beat_valid && cnt_last;
         end
         DRAIN: begin
            cnt_en    = 1'b1;
            cnt_limit = CNT_W'(DRAIN_CYCLES);
         end
         default: ;
      endcase
   end

   acc_beat_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load),
      .enable (cnt_en),
      .limit  (cnt_limit),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         len_q             <= '0;
         addr_q            <= '0;
         cmd_ready         <= 1'b1;
         acc_reset         <= 1'b0;
         store_output      <= 1'b0;
         op_buffer_address <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         err_overrun       <= 1'b0;
      end else begin
         acc_reset         <= 1'b0;
         store_output      <= 1'b0;
         done              <= 1'b0;
         op_buffer_address <= '0;

         // A beat outside ACCUM is dropped but remembered until reset.
         if (beat_valid && (state != ACCUM)) begin
            err_overrun <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state     <= CLEAR;
                  len_q     <= cmd_len;
`ifndef ACC_CTRL_AUTO_ADDR_EN
                  addr_q    <= cmd_addr;
`endif
                  acc_reset <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            CLEAR: begin
               state <= (len_q != '0) ? ACCUM : DRAIN;
            end
            ACCUM: begin
               if (beat_valid && cnt_last) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_last) begin
                  state             <= STORE;
                  store_output      <= 1'b1;
                  done              <= 1'b1;
                  op_buffer_address <= addr_q;
               end
            end
            STORE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
`ifdef ACC_CTRL_AUTO_ADDR_EN
               addr_q    <= next_addr(addr_q);
`endif
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Scoreboard bench for accumulator_ctrl: stimulus queues expected stores,
// a negedge monitor pops and compares each store_output pulse.
module tb_accumulator_ctrl;

   localparam int LEN_W = 8;
   localparam int DRAIN = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             beat_valid = 1'b0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic [3:0]       cmd_addr = '0;
   logic             cmd_ready, acc_reset, store_output, busy, done, err_overrun;
   logic [3:0]       op_buffer_address;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [3:0] auto_addr = '0;

   typedef struct {
      int         at;
      logic [3:0] addr;
   } exp_t;
   exp_t exp_q[$];

   accumulator_ctrl #(
      .ARR_SIZE     (4),
      .LEN_W        (LEN_W),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_len           (cmd_len),
      .cmd_addr          (cmd_addr),
      .beat_valid        (beat_valid),
      .acc_reset         (acc_reset),
      .store_output      (store_output),
      .op_buffer_address (op_buffer_address),
      .busy              (busy),
      .done              (done),
      .err_overrun       (err_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int at, input logic [3:0] addr);
      exp_t e;
      e.at = at;
`ifdef ACC_CTRL_AUTO_ADDR_EN
      e.addr    = auto_addr;
      auto_addr = auto_addr + 4'd1;
`else
      e.addr = addr;
`endif
      exp_q.push_back(e);
   endtask

   // Returns acceptance cycle t; leaves the bench at cycle t+2 (first ACCUM cycle).
   task automatic issue(input int len, input logic [3:0] addr, output int t);
      int n;
      n = 0;
      while (!cmd_ready && n < 1000) begin
         step();
         n++;
      end
      check("cmd_ready_wait", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      cmd_addr  = addr;
      t         = cyc;
      step();
      cmd_valid = 1'b0;
      check("acc_reset_in_clear", int'(acc_reset), 1);
      check("busy_in_clear", int'(busy), 1);
      check("cmd_ready_in_clear", int'(cmd_ready), 0);
      step();
      check("acc_reset_one_cycle", int'(acc_reset), 0);
   endtask

   task automatic beats(input int n);
      for (int i = 0; i < n; i++) begin
         beat_valid = 1'b1;
         step();
      end
      beat_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 1000) begin
         step();
         n++;
      end
      check("return_to_idle", int'(cmd_ready), 1);
   endtask

   // Monitor: every store pulse must match the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (store_output) begin
               check("store_expected", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("store_cycle", cyc, e.at);
                  check("store_addr", int'(op_buffer_address), int'(e.addr));
                  check("store_done", int'(done), 1);
               end
            end else begin
               check("addr_zero_without_store", int'(op_buffer_address), 0);
               check("done_without_store", int'(done), 0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t;
      int         prev;
      logic [6:0] gaps;
      logic [3:0] a;

      #2 rst = 1'b0;
      #10;
      check("rst_acc_reset", int'(acc_reset), 0);
      check("rst_store_output", int'(store_output), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err_overrun", int'(err_overrun), 0);
      check("rst_addr", int'(op_buffer_address), 0);
      step();
      rst = 1'b1;
      #1;
      check("cmd_ready_after_rst", int'(cmd_ready), 1);
      step();

      // len=3 addr=5, consecutive beats
      issue(3, 4'd5, t);
      push_exp(t + 2 + 3 + DRAIN, 4'd5);
      beats(3);
      wait_idle();

      // len=0 addr=9 skips ACCUM
      issue(0, 4'd9, t);
      push_exp(t + 4, 4'd9);
      wait_idle();

      // len=4 with gapped beats; cmd_valid held during the tile must be ignored
      issue(4, 4'd12, t);
      push_exp(t + 11, 4'd12);
      gaps      = 7'b1100101;
      cmd_valid = 1'b1;
      cmd_addr  = 4'd7;
      for (int i = 0; i < 7; i++) begin
         beat_valid = gaps[i];
         step();
      end
      beat_valid = 1'b0;
      cmd_valid  = 1'b0;
      wait_idle();

      // maximum length, no counter wrap
      issue(255, 4'd3, t);
      push_exp(t + 2 + 255 + DRAIN, 4'd3);
      beats(255);
      wait_idle();
      check("no_overrun_yet", int'(err_overrun), 0);

      // stray beat in IDLE sets the sticky flag
      beat_valid = 1'b1;
      step();
      beat_valid = 1'b0;
      check("overrun_set", int'(err_overrun), 1);
      issue(1, 4'd2, t);
      push_exp(t + 2 + 1 + DRAIN, 4'd2);
      beats(1);
      wait_idle();
      check("overrun_sticky", int'(err_overrun), 1);

      // reset mid-ACCUM abandons the tile
      issue(4, 4'd6, t);
      beats(2);
      #2 rst = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_acc_reset", int'(acc_reset), 0);
      check("midrst_store", int'(store_output), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_err", int'(err_overrun), 0);
      check("midrst_addr", int'(op_buffer_address), 0);
      auto_addr = '0;
      step();
      rst = 1'b1;
      #1;
      check("midrst_cmd_ready", int'(cmd_ready), 1);
      for (int i = 0; i < 10; i++) step();

      // 17 back-to-back single-beat commands
      prev = 0;
      for (int i = 0; i < 17; i++) begin
         a = 4'((i * 7) % 16);
         issue(1, a, t);
         if (i > 0) check("back_to_back_accept", t, prev + 1);
         prev = t + 2 + 1 + DRAIN;
         push_exp(prev, a);
         beats(1);
      end
      wait_idle();

      for (int i = 0; i < 5; i++) step();
      check("pending_stores", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/accumulator_ctrl.md
ACCUMULATOR_CTRL -- requirements
Module: accumulator_ctrl

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 4, systolic array width (informational, sizes nothing internally).
REQ-002 SHALL have parameter LEN_W, default 8, width of the beat-count field.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2, accumulator adder pipeline depth to wait before storing (legal 1..15).
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cmd_valid  input  1  tile command offered.
REQ-007 SHALL have port: cmd_ready  output  1  controller can accept a command.
REQ-008 SHALL have port: cmd_len  input  LEN_W  number of partial-sum beats to accumulate.
REQ-009 SHALL have port: cmd_addr  input  4  output buffer address for the result.
REQ-010 SHALL have port: beat_valid  input  1  array presents one partial-sum beat this cycle.
REQ-011 SHALL have port: acc_reset  output  1  clears accumulator.
REQ-012 SHALL have port: store_output  output  1  commands accumulator to write result.
REQ-013 SHALL have port: op_buffer_address  output  4  result address, valid with store_output.
REQ-014 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: err_overrun  output  1  sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, ACCUM, DRAIN, STORE; all outputs registered.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; command accepted on cycle T when cmd_valid&&cmd_ready; cmd_len/cmd_addr latched at T.
REQ-019 SHALL enter CLEAR at T+1 with acc_reset=1 for exactly that one cycle.
REQ-020 SHALL go CLEAR->ACCUM if latched len>0, else CLEAR->DRAIN.
REQ-021 SHALL in ACCUM count cycles with beat_valid=1; on the beat raising count to len, transition to DRAIN next cycle; beat_valid=0 stalls without timeout.
REQ-022 SHALL remain in DRAIN exactly DRAIN_CYCLES cycles, then enter STORE.
REQ-023 SHALL in STORE assert store_output=1, done=1 and op_buffer_address=latched address for exactly one cycle, then return to IDLE.
REQ-024 SHALL hold op_buffer_address at 0 whenever store_output=0.
REQ-025 SHALL set err_overrun when beat_valid=1 in any state other than ACCUM; beat is ignored; flag clears only on reset.
REQ-026 SHALL ignore cmd_valid outside IDLE (no queuing); back-to-back commands possible with first acceptance on the cycle after STORE.
REQ-027 SHALL support len = 2^LEN_W-1 without counter wrap (counter LEN_W bits, compare before increment).

Reset
REQ-028 SHALL on rst=0 asynchronously force IDLE, count=0, address register=0, and all outputs 0 except cmd_ready, which SHALL be 1 once rst deasserts.
REQ-029 SHALL abandon any in-flight command on reset mid-operation without issuing store_output.

Configuration
REQ-030 SHALL, with ACC_CTRL_AUTO_ADDR_EN defined, ignore cmd_addr and use an internal 4-bit address counter reset to 0, incremented after each STORE, wrapping 15->0.
REQ-031 SHALL, without ACC_CTRL_AUTO_ADDR_EN, use cmd_addr latched at acceptance; no address counter exists.

Structure
REQ-032 SHALL take FSM state enum and ACC_ADDR_W=4 from shared package acc_pkg.
REQ-033 SHALL implement DRAIN/ACCUM counting in one sub-module acc_beat_counter (load, enable, terminal-count flag).

Verification
REQ-034 SHALL cover: reset, then cmd len=3 addr=5, beats on 3 consecutive cycles -> acc_reset at T+1, store_output+done with address 5 at T+2+3+DRAIN_CYCLES.
REQ-035 SHALL cover: len=0 addr=9 -> CLEAR, DRAIN (2 cycles), STORE at T+4 with address 9.
REQ-036 SHALL cover: len=4 with beat_valid gaps (1,0,1,0,0,1,1) -> STORE exactly DRAIN_CYCLES+1 cycles after the 4th beat.
REQ-037 SHALL cover: beat_valid=1 in IDLE -> err_overrun=1 persists through next command until rst.
REQ-038 SHALL cover: rst pulsed low mid-ACCUM -> outputs 0 immediately, no store_output, cmd_ready=1 after release.
REQ-039 SHALL cover: with ACC_CTRL_AUTO_ADDR_EN, 17 commands -> addresses 0..15 then 0.
